// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit_pkg
// Brief    : Shared types and constants for the instruction-fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

  localparam logic [31:0] c_reset_pc  = 32'h0000_0000;
  localparam logic [31:0] c_pc_step   = 32'd4;
  // Instruction fetches are always word aligned; low address bits are dropped.
  localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage : if_fetch_unit_pkg
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit_if
// Brief    : Instruction-memory bus plus IF/ID hand-off of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_unit_if;

  // instruction memory side
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // IF/ID side
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stall;

  // fetch unit
  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_inst,
    input  imem_gnt, imem_rvalid, imem_rdata, stall
  );

  // memory and downstream pipeline
  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_inst,
    output imem_gnt, imem_rvalid, imem_rdata, stall
  );

endinterface : if_fetch_unit_if
`default_nettype wire

// File: rtl/if_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small synchronous FIFO of fetch entries with push/pop/clear.
//            A pop and a push in the same cycle keep the count unchanged;
//            clear empties the FIFO and wins over push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  fetch_entry_t                 i_push_data,
  input  logic                         i_pop,
  input  logic                         i_clear,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   c_last  = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   c_depth = CW'(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == c_last) ? '0 : p + PW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_depth);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // a full FIFO may still accept a push when the head leaves in the same cycle
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction-fetch stage. Owns the PC, issues in-order imem
//            requests under a credit limit, buffers returned words and
//            presents {pc, inst} to IF/ID. A taken branch/jump redirects the
//            PC, flushes younger stages and discards in-flight responses.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc,
  parameter int          DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   jump,
  input  logic [31:0]            jump_target,
  if_fetch_unit_if.master        bus,
  output logic                   flush
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW:0]   c_credit = (CW + 1)'(DEPTH);

  fetch_state_e    r_state;
  logic [31:0]     r_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_stale;

  fetch_entry_t    w_req_entry;
  fetch_entry_t    w_req_head;
  fetch_entry_t    w_buf_entry;
  fetch_entry_t    w_buf_head;
  logic [CW-1:0]   w_req_count;
  logic [CW-1:0]   w_buf_count;
  logic            w_req_empty;
  logic            w_req_full;
  logic            w_buf_empty;
  logic            w_buf_full;

  logic [31:0]     w_target;
  logic            w_redirect;
  logic            w_credit;
  logic            w_issue;
  logic            w_rsp_live;
  logic            w_rsp_killed;
  logic            w_consume;
  logic [CW-1:0]   w_stale_jump;
  logic [CW-1:0]   w_stale_drain;
  logic [CW-1:0]   w_outstanding_next;
  logic            w_unused;

  assign w_target   = jump_target & c_word_mask;
  // BOOT has nothing in flight and nothing downstream to kill
  assign w_redirect = jump & (r_state != BOOT);
  assign flush      = w_redirect;

  // Outstanding requests plus buffered words never exceed the buffer depth,
  // so every response is guaranteed a free slot.
  assign w_credit      = ({1'b0, r_outstanding} + {1'b0, w_buf_count}) < c_credit;
  assign bus.imem_req  = (r_state == RUN) & ~jump & w_credit;
  assign bus.imem_addr = r_pc;
  assign w_issue       = bus.imem_req & bus.imem_gnt;

  // A response arriving with a redirect belongs to the old stream: it is
  // dropped and retires one of the pre-jump outstanding requests.
  assign w_rsp_live   = bus.imem_rvalid & (r_state == RUN) & ~jump & (r_outstanding != '0);
  assign w_rsp_killed = bus.imem_rvalid & (r_state == RUN) &  jump & (r_outstanding != '0);

  assign w_stale_jump       = r_outstanding + CW'(w_issue) - CW'(w_rsp_killed);
  assign w_stale_drain      = r_stale - CW'(bus.imem_rvalid & (r_stale != '0));
  assign w_outstanding_next = r_outstanding + CW'(w_issue) - CW'(w_rsp_live);

  assign bus.if_valid = ~w_buf_empty;
  assign w_consume    = bus.if_valid & ~bus.stall;
  assign bus.if_pc    = bus.if_valid ? w_buf_head.pc   : 32'h0;
  assign bus.if_inst  = bus.if_valid ? w_buf_head.inst : 32'h0;

  assign w_req_entry = '{pc: r_pc, inst: 32'h0};
  assign w_buf_entry = '{pc: w_req_head.pc, inst: bus.imem_rdata};

  // PCs of issued requests, matched in order against returning words
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_req_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_issue),
    .i_push_data (w_req_entry),
    .i_pop       (w_rsp_live),
    .i_clear     (w_redirect),
    .o_head      (w_req_head),
    .o_count     (w_req_count),
    .o_empty     (w_req_empty),
    .o_full      (w_req_full)
  );

  // fetched {pc, inst} pairs waiting for IF/ID
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_rsp_live),
    .i_push_data (w_buf_entry),
    .i_pop       (w_consume),
    .i_clear     (w_redirect),
    .o_head      (w_buf_head),
    .o_count     (w_buf_count),
    .o_empty     (w_buf_empty),
    .o_full      (w_buf_full)
  );

  assign w_unused = &{1'b0, w_req_head.inst, w_req_count, w_req_empty, w_req_full, w_buf_full};

  // fetch control FSM: PC, credit accounting and stale-response draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_stale       <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= RUN;
        end
        RUN: begin
          if (jump) begin
            r_pc          <= w_target;
            r_outstanding <= '0;
            r_stale       <= w_stale_jump;
            r_state       <= (w_stale_jump != '0) ? DRAIN : RUN;
          end else begin
            if (w_issue) r_pc <= r_pc + c_pc_step;
            r_outstanding <= w_outstanding_next;
          end
        end
        DRAIN: begin
          if (jump) r_pc <= w_target;
          r_stale <= w_stale_drain;
          if (w_stale_drain == '0) r_state <= RUN;
        end
        default: begin
          r_state <= BOOT;
        end
      endcase
    end
  end

endmodule : if_fetch_unit
`default_nettype wire
